// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 refresh controller.
// The byte writer and the sequencing FSM both import this package.
package lcd_pkg;

   typedef enum logic [2:0] {PWRUP, INIT, IDLE, START, FETCH, BYTE, DONE} state_t;
   typedef enum logic [1:0] {PH_INIT, PH_LINE1, PH_CHAR, PH_LINE2} phase_t;
   typedef enum logic [2:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD, W_WAIT} wr_state_t;

   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_LINE1    = 8'h80;
   localparam logic [7:0] LCD_LINE2    = 8'hC0;

   // Bits needed to count 0..max_val-1 without overflow, never less than 1.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : int'($clog2(max_val + 1));
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return LCD_FUNC_SET;
         2'd1:    return LCD_DISP_ON;
         2'd2:    return LCD_ENTRY;
         default: return LCD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte to the panel: SETUP, E pulse, HOLD, then the settle wait.
// rs/data are captured on start and held untouched until the next start.
module lcd_byte_writer import lcd_pkg::*; #(
   parameter int unsigned E_PULSE_CYC  = 25,
   parameter int unsigned CMD_WAIT_CYC = 2500,
   parameter int unsigned CLR_WAIT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   input  logic       long_wait,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       done
);

   localparam int unsigned MAX_WAIT = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
   localparam int unsigned MAX_CYC  = (MAX_WAIT > E_PULSE_CYC) ? MAX_WAIT : E_PULSE_CYC;
   localparam int unsigned CW       = cnt_width(MAX_CYC);

   wr_state_t       state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   wait_last;
   logic            long_r;

   assign wait_last = long_r ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);

   // Handshake: start is a one-cycle request honoured only in W_IDLE;
   // done is a one-cycle pulse once the settle wait has fully elapsed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= W_IDLE;
         cnt      <= '0;
         long_r   <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_e    <= 1'b0;
         lcd_data <= 8'h00;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            W_IDLE: if (start) begin
               lcd_rs   <= rs;
               lcd_data <= data;
               long_r   <= long_wait;
               state    <= W_SETUP;
            end
            W_SETUP: begin
               lcd_e <= 1'b1;
               cnt   <= '0;
               state <= W_STROBE;
            end
            W_STROBE: begin
               if (cnt == CW'(E_PULSE_CYC - 1)) begin
                  lcd_e <= 1'b0;
                  state <= W_HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            W_HOLD: begin
               cnt   <= '0;
               state <= W_WAIT;
            end
            W_WAIT: begin
               if (cnt == wait_last) begin
                  done  <= 1'b1;
                  state <= W_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Sequences power-up, panel init and full 32-character redraws of the
// instruction label; a redraw uses a snapshot of opcode/imm4 taken at START.
module lcd_refresh_ctrl import lcd_pkg::*; #(
   parameter int unsigned PWRUP_CYC    = 750000,
   parameter int unsigned E_PULSE_CYC  = 25,
   parameter int unsigned CMD_WAIT_CYC = 2500,
   parameter int unsigned CLR_WAIT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic [3:0] imm4,
   input  logic       refresh,
   output logic [4:0] rom_addr,
   output logic [3:0] rom_opcode,
   output logic [3:0] rom_imm4,
   input  logic [7:0] rom_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       busy
);

   localparam int unsigned PW = cnt_width(PWRUP_CYC);

   state_t         state;
   phase_t         phase;
   logic [PW-1:0]  pwr_cnt;
   logic [1:0]     init_idx;
   logic           shown_valid;
   logic           pending;
   logic           wr_start;
   logic           wr_rs;
   logic [7:0]     wr_data;
   logic           wr_long;
   logic           wr_done;
   logic           redraw_req;

   assign lcd_rw     = 1'b0;
   assign redraw_req = refresh | pending | ~shown_valid |
                       ({opcode, imm4} != {rom_opcode, rom_imm4});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= PWRUP;
         phase       <= PH_INIT;
         pwr_cnt     <= '0;
         init_idx    <= 2'd0;
         shown_valid <= 1'b0;
         pending     <= 1'b0;
         rom_addr    <= 5'd0;
         rom_opcode  <= 4'd0;
         rom_imm4    <= 4'd0;
         busy        <= 1'b1;
         wr_start    <= 1'b0;
         wr_rs       <= 1'b0;
         wr_data     <= 8'h00;
         wr_long     <= 1'b0;
      end else begin
         wr_start <= 1'b0;
         // Requests while busy collapse into a single pending redraw.
         if (refresh && state != IDLE) pending <= 1'b1;
         case (state)
            PWRUP: begin
               if (pwr_cnt == PW'(PWRUP_CYC - 1)) state <= INIT;
               else pwr_cnt <= pwr_cnt + 1'b1;
            end
            INIT: begin
               wr_start <= 1'b1;
               wr_rs    <= 1'b0;
               wr_data  <= init_cmd(init_idx);
               wr_long  <= (init_cmd(init_idx) == LCD_CLEAR);
               phase    <= PH_INIT;
               state    <= BYTE;
            end
            IDLE: begin
               if (redraw_req) begin
                  busy  <= 1'b1;
                  state <= START;
               end
            end
            START: begin
               // A refresh in this very cycle arrives after the snapshot.
               pending    <= refresh;
               rom_opcode <= opcode;
               rom_imm4   <= imm4;
               rom_addr   <= 5'd0;
               wr_start   <= 1'b1;
               wr_rs      <= 1'b0;
               wr_data    <= LCD_LINE1;
               wr_long    <= 1'b0;
               phase      <= PH_LINE1;
               state      <= BYTE;
            end
            FETCH: begin
               wr_start <= 1'b1;
               wr_rs    <= 1'b1;
               wr_data  <= rom_data;
               wr_long  <= 1'b0;
               phase    <= PH_CHAR;
               state    <= BYTE;
            end
            BYTE: begin
               if (wr_done) begin
                  case (phase)
                     PH_INIT: begin
                        if (init_idx == 2'd3) begin
                           busy  <= 1'b0;
                           state <= IDLE;
                        end else begin
                           init_idx <= init_idx + 2'd1;
                           state    <= INIT;
                        end
                     end
                     PH_LINE1: state <= FETCH;
                     PH_CHAR: begin
                        if (rom_addr == 5'd31) begin
                           state <= DONE;
                        end else if (rom_addr == 5'd15) begin
                           wr_start <= 1'b1;
                           wr_rs    <= 1'b0;
                           wr_data  <= LCD_LINE2;
                           wr_long  <= 1'b0;
                           phase    <= PH_LINE2;
                        end else begin
                           rom_addr <= rom_addr + 5'd1;
                           state    <= FETCH;
                        end
                     end
                     default: begin
                        rom_addr <= rom_addr + 5'd1;
                        state    <= FETCH;
                     end
                  endcase
               end
            end
            DONE: begin
               shown_valid <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= PWRUP;
         endcase
      end
   end

   lcd_byte_writer #(
      .E_PULSE_CYC  (E_PULSE_CYC),
      .CMD_WAIT_CYC (CMD_WAIT_CYC),
      .CLR_WAIT_CYC (CLR_WAIT_CYC)
   ) u_writer (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (wr_start),
      .rs        (wr_rs),
      .data      (wr_data),
      .long_wait (wr_long),
      .lcd_rs    (lcd_rs),
      .lcd_e     (lcd_e),
      .lcd_data  (lcd_data),
      .done      (wr_done)
   );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: every E strobe is matched against a queue of
// expected {rom_opcode, rom_imm4, rs, data} words pushed with the stimulus.
module tb_lcd_refresh_ctrl;
   import lcd_pkg::*;

   localparam int PWRUP_CYC    = 20;
   localparam int E_PULSE_CYC  = 2;
   localparam int CMD_WAIT_CYC = 4;
   localparam int CLR_WAIT_CYC = 10;
   localparam int W            = 17;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic [3:0] imm4 = 4'd0;
   logic       refresh = 1'b0;
   logic [4:0] rom_addr;
   logic [3:0] rom_opcode;
   logic [3:0] rom_imm4;
   logic [7:0] rom_data;
   logic       lcd_rs, lcd_rw, lcd_e, busy;
   logic [7:0] lcd_data;

   assign rom_data = 8'h40 + {3'b000, rom_addr};

   lcd_refresh_ctrl #(
      .PWRUP_CYC    (PWRUP_CYC),
      .E_PULSE_CYC  (E_PULSE_CYC),
      .CMD_WAIT_CYC (CMD_WAIT_CYC),
      .CLR_WAIT_CYC (CLR_WAIT_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .imm4       (imm4),
      .refresh    (refresh),
      .rom_addr   (rom_addr),
      .rom_opcode (rom_opcode),
      .rom_imm4   (rom_imm4),
      .rom_data   (rom_data),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_e      (lcd_e),
      .lcd_data   (lcd_data),
      .busy       (busy)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_fail = 0;
   int strobe_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] vec(input logic [3:0] op, input logic [3:0] im,
                                        input logic rs, input logic [7:0] d);
      return {op, im, rs, d};
   endfunction

   task automatic push_init();
      exp_q.push_back(vec(4'd0, 4'd0, 1'b0, 8'h38));
      exp_q.push_back(vec(4'd0, 4'd0, 1'b0, 8'h0C));
      exp_q.push_back(vec(4'd0, 4'd0, 1'b0, 8'h06));
      exp_q.push_back(vec(4'd0, 4'd0, 1'b0, 8'h01));
   endtask

   task automatic push_redraw(input logic [3:0] op, input logic [3:0] im);
      exp_q.push_back(vec(op, im, 1'b0, 8'h80));
      for (int i = 0; i < 16; i++) exp_q.push_back(vec(op, im, 1'b1, 8'(8'h40 + i)));
      exp_q.push_back(vec(op, im, 1'b0, 8'hC0));
      for (int i = 16; i < 32; i++) exp_q.push_back(vec(op, im, 1'b1, 8'(8'h40 + i)));
   endtask

   // ---------------- strobe monitor ----------------
   logic       prev_e = 1'b0;
   logic       prev_rs = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [8:0] last_byte = 9'h000;
   logic       have_last = 1'b0;
   logic       after_reset = 1'b1;
   int         hi_cnt = 0;
   int         gap = 0;
   int         wait_cyc = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_e      = 1'b0;
         hi_cnt      = 0;
         gap         = 0;
         have_last   = 1'b0;
         after_reset = 1'b1;
      end else begin
         if (lcd_e && !prev_e) begin
            strobe_cnt++;
            if (after_reset) begin
               check("pwrup_gap", 32'(gap >= PWRUP_CYC), 32'd1);
            end else if (have_last) begin
               wait_cyc = (last_byte == {1'b0, LCD_CLEAR}) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
               check("gap_min", 32'(gap >= wait_cyc + 2), 32'd1);
               if (last_byte != {1'b1, 8'h5F})
                  check("gap_max", 32'(gap <= wait_cyc + 8), 32'd1);
            end
            after_reset = 1'b0;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
               check("strobe", 32'({rom_opcode, rom_imm4, lcd_rs, lcd_data}), 32'(exp_q.pop_front()));
            hi_cnt = 1;
         end else if (lcd_e) begin
            hi_cnt++;
            check("stable_hi", 32'({lcd_rs, lcd_data}), 32'({prev_rs, prev_data}));
         end else if (prev_e) begin
            check("e_width", 32'(hi_cnt), 32'(E_PULSE_CYC));
            check("stable_hold", 32'({lcd_rs, lcd_data}), 32'({prev_rs, prev_data}));
            last_byte = {lcd_rs, lcd_data};
            have_last = 1'b1;
            gap = 1;
         end else begin
            gap++;
         end
         prev_e    = lcd_e;
         prev_rs   = lcd_rs;
         prev_data = lcd_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_in_time"}, 32'(n < budget), 32'd1);
   endtask

   task automatic wait_strobes(input int target, input int budget);
      int n = 0;
      while (strobe_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("strobe_wait_in_time", 32'(n < budget), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   int base;

   initial begin
      opcode = 4'b0101;
      imm4   = 4'b0011;
      repeat (3) @(negedge clk);
      check("rst_e",      32'(lcd_e),      32'd0);
      check("rst_rs",     32'(lcd_rs),     32'd0);
      check("rst_rw",     32'(lcd_rw),     32'd0);
      check("rst_data",   32'(lcd_data),   32'h00);
      check("rst_addr",   32'(rom_addr),   32'd0);
      check("rst_opcode", 32'(rom_opcode), 32'd0);
      check("rst_imm4",   32'(rom_imm4),   32'd0);
      check("rst_busy",   32'(busy),       32'd1);

      // Power-up, init and the first automatic redraw.
      push_init();
      push_redraw(4'b0101, 4'b0011);
      rst_n = 1'b1;
      wait_idle("first", 4000);
      check("first_busy",   32'(busy),       32'd0);
      check("first_count",  32'(strobe_cnt), 32'd38);
      check("first_addr",   32'(rom_addr),   32'd31);
      check("first_opcode", 32'(rom_opcode), 32'b0101);
      check("first_imm4",   32'(rom_imm4),   32'b0011);

      // Opcode changes at character 5: current redraw keeps the snapshot,
      // one automatic redraw with the new opcode follows.
      base = strobe_cnt;
      push_redraw(4'b0101, 4'b0011);
      pulse_refresh();
      wait_strobes(base + 6, 1000);
      opcode = 4'b0010;
      push_redraw(4'b0010, 4'b0011);
      check("snap_mid", 32'(rom_opcode), 32'b0101);
      wait_idle("opchange", 4000);
      repeat (200) @(negedge clk);
      check("opchange_count", 32'(strobe_cnt), 32'(base + 68));
      check("opchange_opcode", 32'(rom_opcode), 32'b0010);

      // Three refresh pulses inside one redraw collapse into one extra redraw.
      base = strobe_cnt;
      push_redraw(4'b0010, 4'b0011);
      push_redraw(4'b0010, 4'b0011);
      pulse_refresh();
      for (int k = 0; k < 3; k++) begin
         wait_strobes(base + 3 + 10 * k + int'($urandom_range(0, 5)), 1000);
         pulse_refresh();
      end
      wait_idle("triple", 4000);
      repeat (300) @(negedge clk);
      check("triple_count", 32'(strobe_cnt), 32'(base + 68));
      check("triple_busy",  32'(busy),       32'd0);

      // Refresh in the same cycle as the IDLE exit is absorbed.
      base = strobe_cnt;
      opcode  = 4'b1001;
      imm4    = 4'b1010;
      push_redraw(4'b1001, 4'b1010);
      pulse_refresh();
      wait_idle("same_cycle", 4000);
      repeat (300) @(negedge clk);
      check("same_cycle_count", 32'(strobe_cnt), 32'(base + 34));
      check("same_cycle_busy",  32'(busy),       32'd0);

      // Asynchronous reset while E is high in the middle of a character.
      base = strobe_cnt;
      push_redraw(4'b1001, 4'b1010);
      pulse_refresh();
      wait_strobes(base + 10, 1000);
      for (int n = 0; n < 200 && !lcd_e; n++) @(negedge clk);
      check("e_before_reset", 32'(lcd_e), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_e",      32'(lcd_e),      32'd0);
      check("arst_data",   32'(lcd_data),   32'h00);
      check("arst_rs",     32'(lcd_rs),     32'd0);
      check("arst_busy",   32'(busy),       32'd1);
      check("arst_addr",   32'(rom_addr),   32'd0);
      check("arst_opcode", 32'(rom_opcode), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      base = strobe_cnt;
      push_init();
      push_redraw(4'b1001, 4'b1010);
      rst_n = 1'b1;
      wait_idle("after_reset", 4000);
      check("after_reset_count",  32'(strobe_cnt), 32'(base + 38));
      check("after_reset_opcode", 32'(rom_opcode), 32'b1001);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_refresh_ctrl.md
Name: lcd_refresh_ctrl

Overview:
- Sequences an HD44780-style 16x2 character LCD (8-bit bus, write-only) showing the current instruction.
- Runs power-up init, then repeatedly walks the 32 character positions of the existing combinational label ROM (5-bit addr plus opcode/imm4 in, 8-bit ASCII out). Each character is strobed to the panel with the required E timing.
- Sits between the CPU's instruction register and the LCD pins.

Parameters:
- PWRUP_CYC, 750000, cycles to wait after reset before the first command (15 ms at 50 MHz).
- E_PULSE_CYC, 25, cycles lcd_e is held high per byte (>=1).
- CMD_WAIT_CYC, 2500, post-strobe wait for commands and data (50 us).
- CLR_WAIT_CYC, 100000, post-strobe wait after clear 0x01 (2 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  live instruction opcode
- imm4  in  4  live instruction immediate
- refresh  in  1  single-cycle request to redraw even if unchanged
- rom_addr  out  5  character position to ROM (0-15 line 1, 16-31 line 2)
- rom_opcode  out  4  snapshotted opcode to ROM
- rom_imm4  out  4  snapshotted imm4 to ROM
- rom_data  in  8  ROM character, combinational from rom_* outputs
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_e  out  1  enable strobe
- lcd_data  out  8  LCD data bus
- busy  out  1  high whenever not in IDLE

Behaviour:
- Reset (async, immediate, also mid-operation) forces:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, rom_addr=0, rom_opcode=0, rom_imm4=0, busy=1.
  - shown_valid=0, pending=0, state=PWRUP.
- Byte write (sub-sequence used for every byte):
  - SETUP: 1 cycle, rs/data stable, e=0.
  - STROBE: E_PULSE_CYC cycles, e=1.
  - HOLD: 1 cycle, e=0, data held.
  - WAIT: CMD_WAIT_CYC cycles, or CLR_WAIT_CYC for 0x01.
  - Total = 2 + E_PULSE_CYC + wait cycles. lcd_data and lcd_rs never change while e=1 or in HOLD.
- State machine:
  - PWRUP: count PWRUP_CYC, then INIT.
  - INIT: write commands 0x38, 0x0C, 0x06, 0x01 in order, rs=0, then IDLE.
  - IDLE (busy=0): start a refresh if pending=1, or shown_valid=0, or {opcode,imm4} != snapshot.
  - START: snapshot {opcode,imm4} into rom_opcode/rom_imm4, clear pending. Write command 0x80, rs=0.
  - CHAR: for n=0..31, run FETCH then a data byte write (rs=1).
    - FETCH is 1 cycle: rom_addr=n, lcd_data <= rom_data at its end.
    - After n=15 completes, write command 0xC0 before n=16.
  - DONE: set shown_valid=1, return to IDLE.
  - Bytes per refresh: 34 (2 commands + 32 characters).
- Boundary conditions:
  - refresh while busy sets pending; any number of requests during one redraw collapse into exactly one extra redraw.
  - refresh in the same cycle as IDLE exit is absorbed by that redraw.
  - opcode/imm4 changing mid-redraw do not affect the current redraw (snapshot). If they differ from the snapshot when IDLE is reached, an automatic redraw follows.
  - rom_addr holds its last value (31) in IDLE. rom_addr wraps only via explicit reset to 0 at START.
  - Counters must be wide enough for the largest parameter; no overflow at any parameter value >= 1.

Decomposition:
- lcd_pkg holds the state enum (PWRUP, INIT, IDLE, START, FETCH, BYTE, DONE) and command constants:
  - LCD_FUNC_SET=0x38, LCD_DISP_ON=0x0C, LCD_ENTRY=0x06, LCD_CLEAR=0x01, LCD_LINE1=0x80, LCD_LINE2=0xC0.
- One sub-module, lcd_byte_writer, implements the byte write: start, rs, data, long_wait in; lcd_* and done out. The top FSM handles sequencing only.

Test Plan (PWRUP=20, E_PULSE=2, CMD_WAIT=4, CLR_WAIT=10):
- Reset release:
  - lcd_e stays 0 for 20 cycles.
  - Then bytes 0x38, 0x0C, 0x06, 0x01 appear, each with rs=0 and e high for exactly 2 cycles.
  - 0x01 is followed by a 10-cycle gap.
- First redraw with opcode=0101, imm4=0011, ROM model returning 0x40+addr:
  - 34 strobes: 0x80, 0x40..0x4F, 0xC0, 0x50..0x5F.
  - rs=1 only on the 32 characters.
  - rom_opcode=0101 throughout. busy drops after the last wait.
- Change opcode to 0010 at character 5 of a redraw:
  - rom_opcode stays 0101 until DONE.
  - Exactly one further redraw follows, with rom_opcode=0010.
- Three refresh pulses during one redraw:
  - Exactly one extra 34-byte redraw, then busy=0 with no further strobes.
- Assert rst_n low while e=1 mid-character:
  - lcd_e, lcd_data and busy=1 change combinationally to reset values.
  - After release, the full PWRUP/INIT sequence repeats.
- Data stability checker over all scenarios: lcd_data and lcd_rs never change while lcd_e=1 or in the cycle after lcd_e falls.
